// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: owns the PC, issues sync-read requests
//               and buffers returned words with their PC for the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned BUF_DEPTH   = 2,
    parameter logic [31:0] HALT_ENCODE = 32'h0000_003F
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_inflight;
    logic [31:0]        r_mem_data [BUF_DEPTH];
    logic [31:0]        r_mem_pc   [BUF_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_inst_out;
    logic [31:0]        r_inst_pc;
    logic               r_inst_valid;

    logic               w_pop;
    logic               w_req;
    logic               w_wr_en;
    logic               w_redirect;
    logic [c_cnt_w-1:0] w_occ;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [31:0]        w_head_data;
    logic [31:0]        w_head_pc;

    assign w_pop      = r_inst_valid & inst_ready;
    assign w_redirect = redirect & (r_state != S_HALTED);

    // The entry being popped this cycle frees its slot for a new request,
    // which keeps a two-entry buffer streaming one word per cycle.
    assign w_occ = r_count - c_cnt_w'(w_pop) + c_cnt_w'(r_inflight);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req   = !redirect && (w_occ < c_depth);
                w_wr_en = r_inflight && !redirect;
                if (w_wr_en && (imem_rdata == HALT_ENCODE)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Anything still in flight was fetched past the HALT and is dropped.
                if (redirect) begin
                    w_state_nxt = S_FETCH;
                end else if (w_pop && (r_count == c_cnt_w'(1))) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
        if (rst) begin
            w_req   = 1'b0;
            w_wr_en = 1'b0;
        end
    end

    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_pop);
    assign w_cnt_nxt    = r_count - c_cnt_w'(w_pop) + c_cnt_w'(w_wr_en);

    // When the incoming word lands in the slot that becomes the head, bypass it.
    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_pc   = r_mem_pc[w_rd_ptr_nxt];
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_data = imem_rdata;
            w_head_pc   = r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'h0;
            r_inflight   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_inst_out   <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
        end else if (w_redirect) begin
            r_pc         <= redirect_pc;
            r_inflight   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc     <= r_pc + 32'(PC_STEP);
                r_req_pc <= r_pc;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_cnt_nxt;
            r_inst_valid <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) begin
                r_inst_out <= w_head_data;
                r_inst_pc  <= w_head_pc;
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign inst_out   = r_inst_out;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign halted     = (r_state == S_HALTED);

endmodule
`default_nettype wire
